// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// Carries the ovf flag only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf
    );
    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );
    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, WIDTH-cycle latency.
// Optional signed-overflow flag enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;

    logic             a0, b0, d_bit, br_nxt, load;
    logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    // Full-subtractor cell on bit 0 of the operand shift registers
    assign a0      = a_sh_q[0];
    assign b0      = b_sh_q[0];
    assign d_bit   = a0 ^ b0 ^ br_q;
    assign br_nxt  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    assign res_nxt = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        load     = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: load = bus.start;
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_nxt;
                br_d   = br_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_nxt;
                    borrow_d = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d = (a_msb_q != b_msb_q) &&
                            (res_nxt[WIDTH-1] != a_msb_q);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                load    = bus.start;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            a_sh_d  = bus.a;
            b_sh_d  = bus.b;
            res_d   = '0;
            br_d    = 1'b0;
            cnt_d   = '0;
            state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_d = bus.a[WIDTH-1];
            b_msb_d = bus.b[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random WIDTH=8 ops,
// reset abort, and an exhaustive WIDTH=4 sweep against arithmetic.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );
    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    always #5 clk = ~clk;

    logic [7:0] ea, eb;
    logic [7:0] hold_diff;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    task automatic ref_sub(input int w, input int a, input int b,
                           output int rd, output int rb, output int ro);
        int m, sa, sb, sd;
        m  = 1 << w;
        rd = (a - b + m) % m;
        rb = (a < b) ? 1 : 0;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        sd = sa - sb;
        ro = (sd < -(m / 2) || sd > (m / 2) - 1) ? 1 : 0;
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        ea = a;
        eb = b;
        @(negedge clk);
        if8.start = 1'b0;
        if8.a     = 8'($urandom);
        if8.b     = 8'($urandom);
    endtask

    task automatic finish8(input int inj, input logic [7:0] ia,
                           input logic [7:0] ib, input bit chain,
                           input logic [7:0] ca, input logic [7:0] cb);
        int n, rd, rb, ro;
        bit held, busy_ok;
        n = 0;
        held = 1'b1;
        busy_ok = 1'b1;
        while (!if8.done && n < 40) begin
            if (!if8.busy) busy_ok = 1'b0;
            if (if8.diff !== hold_diff) held = 1'b0;
            if (n == inj) begin
                if8.start = 1'b1;
                if8.a = ia;
                if8.b = ib;
            end else begin
                if8.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        if8.start = 1'b0;
        ref_sub(8, int'(ea), int'(eb), rd, rb, ro);
        check("latency", n, 8);
        check("busy_run", busy_ok, 1);
        check("diff_held", held, 1);
        check("diff", if8.diff, rd);
        check("borrow", if8.borrow, rb);
        check("busy_done", if8.busy, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", if8.ovf, ro);
`endif
        hold_diff = 8'(rd);
        if (chain) begin
            launch8(ca, cb);
            check("chain_busy", if8.busy, 1);
        end else begin
            @(negedge clk);
            check("busy_after", if8.busy, 0);
        end
        check("done_pulse", if8.done, 0);
    endtask

    task automatic quiet8(input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (if8.done || if8.busy) seen = 1'b1;
            @(negedge clk);
        end
        check("no_extra_done", seen, 0);
    endtask

    initial begin
        int rd, rb, ro, n;
        rst_n = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0;
        hold_diff = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", if8.busy, 0);
        check("rst_done", if8.done, 0);
        check("rst_diff", if8.diff, 0);
        check("rst_borrow", if8.borrow, 0);
        check("rst4_diff", if4.diff, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        launch8(8'h5A, 8'h3C); finish8(-1, 0, 0, 0, 0, 0);
        check("t1_diff", if8.diff, 8'h1E);
        launch8(8'h00, 8'h01); finish8(-1, 0, 0, 0, 0, 0);
        check("t2a_borrow", if8.borrow, 1);
        launch8(8'h80, 8'h01); finish8(-1, 0, 0, 0, 0, 0);
        check("t2b_diff", if8.diff, 8'h7F);
        launch8(8'h7F, 8'hFF); finish8(-1, 0, 0, 0, 0, 0);
        check("t2c_diff", if8.diff, 8'h80);

        // Start during RUN is ignored
        launch8(8'h10, 8'h01); finish8(2, 8'hFF, 8'hFF, 0, 0, 0);
        check("t3_diff", if8.diff, 8'h0F);
        quiet8(12);

        // Back-to-back start in the DONE cycle
        launch8(8'h44, 8'h11); finish8(-1, 0, 0, 1, 8'h03, 8'h05);
        finish8(-1, 0, 0, 0, 0, 0);
        check("t4_diff", if8.diff, 8'hFE);

        // Reset mid-RUN discards the operation
        launch8(8'h20, 8'h05);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_busy", if8.busy, 0);
        check("t5_done", if8.done, 0);
        check("t5_diff", if8.diff, 0);
        check("t5_borrow", if8.borrow, 0);
        hold_diff = '0;
        quiet8(12);
        launch8(8'h20, 8'h05); finish8(-1, 0, 0, 0, 0, 0);

        // Random operations, some chained
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb8;
            ra  = 8'($urandom);
            rb8 = 8'($urandom);
            launch8(ra, rb8);
            finish8(-1, 0, 0, 0, 0, 0);
        end

        // Exhaustive WIDTH=4 sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if4.start = 1'b1;
                if4.a = 4'(a);
                if4.b = 4'(b);
                @(negedge clk);
                if4.start = 1'b0;
                if4.a = 4'($urandom);
                if4.b = 4'($urandom);
                n = 0;
                while (!if4.done && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                ref_sub(4, a, b, rd, rb, ro);
                check("w4_latency", n, 4);
                check("w4_diff", if4.diff, rd);
                check("w4_borrow", if4.borrow, rb);
`ifdef SERIAL_SUB_OVF_EN
                check("w4_ovf", if4.ovf, ro);
`endif
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor for the calculator datapath: computes diff = a - b, processing one bit per clock, LSB first.
- Per-bit cell is the full-subtractor counterpart of the team's full-adder cell: difference = a ^ b ^ borrow_in.
- Sits beside the ripple adder in the ALU and trades area for a WIDTH-cycle latency.
- Uses a start/busy/done handshake toward the calculator control FSM.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result registers updated in the same cycle
diff  output  WIDTH  result a - b mod 2^WIDTH; held until the next completion
borrow  output  1  final borrow out; 1 iff a < b (unsigned); held with diff

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of state (including mid-RUN, which discards the operation):
  - state = IDLE
  - busy = 0, done = 0
  - diff = 0, borrow = 0
  - internal shift registers, bit counter and running borrow = 0
- State IDLE:
  - busy = 0, done = 0.
  - If start = 1, latch a and b into shift registers, set running borrow = 0 and counter = 0, and go to RUN.
- State RUN:
  - busy = 1.
  - Each edge consumes bit 0 of both shift registers:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d is shifted into the MSB of the result shift register. Operand registers shift right by 1. Counter increments.
  - start is ignored; a and b changes are ignored.
  - On the edge that processes bit WIDTH-1:
    - diff <= completed result
    - borrow <= br_next
    - done <= 1
    - go to DONE
- State DONE (exactly one cycle):
  - busy = 0, done = 1.
  - If start = 1, accept the new operation exactly as in IDLE and go to RUN (back-to-back, no bubble). Otherwise go to IDLE.
  - done returns to 0 on the next edge in either case.
- Latency: the start edge is edge 0. done is high during the cycle following edge WIDTH. Throughput is one result per WIDTH+1 cycles.
- diff and borrow change only at completion or reset; they never show partial results.
- Width rule: result is modulo 2^WIDTH; no sign extension.
- Counter width is clog2(WIDTH)+1. The counter never wraps within an operation.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset value 0, updated together with diff and held until the next completion.
  - ovf = 1 iff signed overflow occurred: a[WIDTH-1] != b[WIDTH-1] and diff[WIDTH-1] != a[WIDTH-1].
  - Computed from the latched MSBs captured at the start edge.
- Undefined:
  - Port ovf is absent.
  - No sign logic is synthesized.
  - All other behaviour is identical.

Test Plan:
1. WIDTH=8: a=0x5A, b=0x3C, start pulse in IDLE -> busy high for 8 cycles; done pulses 1 cycle; diff=0x1E, borrow=0, ovf=0 if enabled.
2. WIDTH=8: a=0x00, b=0x01 -> diff=0xFF, borrow=1. Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1 if enabled. Also a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
3. Start a=0x10, b=0x01, then at cycle 3 of RUN pulse start with a=0xFF, b=0xFF -> second request ignored; result diff=0x0F, borrow=0; exactly one done pulse.
4. Assert start again during the DONE cycle with a=0x03, b=0x05:
   - first result is seen in the DONE cycle;
   - the next done comes 8 edges after that DONE edge, with diff=0xFE, borrow=1;
   - diff holds the first result until then.
5. Drive rst_n low for 1 cycle at RUN cycle 4 -> next cycle busy=0, done=0, diff=0x00, borrow=0. No done pulse follows. A fresh start then completes normally.
6. Exhaustive WIDTH=4 sweep over all 256 (a, b) pairs -> diff == (a - b) & 0xF, borrow == (a < b), and ovf matches the signed rule when SERIAL_SUB_OVF_EN is defined.
